// File: rtl/reg_wb_scheduler.sv
// Arbitrates the reg_file write port between pipeline (R0) and long-latency (R1) writeback and tracks busy registers.
// Grant is combinational; WB_* is registered one cycle later. The losing requester holds until its READY. Issue stalls at MAX_OUTSTANDING.
module reg_wb_scheduler #(
  parameter int NREG            = 32,
  parameter int AW              = 5,
  parameter int DW              = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          R0_VALID,
  input  logic [AW-1:0] R0_ADDR,
  input  logic [DW-1:0] R0_DATA,
  output logic          R0_READY,
  input  logic          R1_VALID,
  input  logic [AW-1:0] R1_ADDR,
  input  logic [DW-1:0] R1_DATA,
  output logic          R1_READY,
  input  logic          ISSUE_EN,
  input  logic [AW-1:0] ISSUE_ADDR,
  output logic          ISSUE_READY,
  input  logic [AW-1:0] RS1_ADDR,
  input  logic [AW-1:0] RS2_ADDR,
  input  logic [AW-1:0] RD_ADDR,
  output logic          HAZARD,
  output logic [DW-1:0] WB_DATA,
  output logic [AW-1:0] WB_ADDR,
  output logic          WB_EN
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  logic [NREG-1:0] busy_q, busy_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            rr_q, rr_d;
  logic            r0_gnt, r1_gnt, issue_acc;
  logic [AW-1:0]   gnt_addr;
  logic [DW-1:0]   gnt_data;

  // rr_q == 0 prefers R0; a contested grant hands priority to the loser
  always_comb begin
    r0_gnt = 1'b0;
    r1_gnt = 1'b0;
    rr_d   = rr_q;
    if (!RESET) begin
      if (R0_VALID && R1_VALID) begin
        r0_gnt = !rr_q;
        r1_gnt = rr_q;
        rr_d   = !rr_q;
      end else begin
        r0_gnt = R0_VALID;
        r1_gnt = R1_VALID;
      end
    end
  end

  assign R0_READY    = r0_gnt;
  assign R1_READY    = r1_gnt;
  assign ISSUE_READY = (cnt_q != MAX_CNT);
  assign issue_acc   = ISSUE_EN && ISSUE_READY;

  assign gnt_addr = r0_gnt ? R0_ADDR : R1_ADDR;
  assign gnt_data = r0_gnt ? R0_DATA : R1_DATA;

  // Set is applied after clear so a same-edge reissue keeps the register busy
  always_comb begin
    busy_d = busy_q;
    if (r1_gnt)
      busy_d[R1_ADDR] = 1'b0;
    if (issue_acc && (ISSUE_ADDR != '0))
      busy_d[ISSUE_ADDR] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (issue_acc && !r1_gnt)
      cnt_d = cnt_q + CW'(1);
    else if (r1_gnt && !issue_acc && (cnt_q != '0))
      cnt_d = cnt_q - CW'(1);
  end

  assign HAZARD = ((RS1_ADDR != '0) && busy_q[RS1_ADDR]) ||
                  ((RS2_ADDR != '0) && busy_q[RS2_ADDR]) ||
                  ((RD_ADDR  != '0) && busy_q[RD_ADDR]);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      busy_q  <= '0;
      cnt_q   <= '0;
      rr_q    <= 1'b0;
      WB_EN   <= 1'b0;
      WB_ADDR <= '0;
      WB_DATA <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      rr_q   <= rr_d;
      WB_EN  <= (r0_gnt || r1_gnt) && (gnt_addr != '0);
      if (r0_gnt || r1_gnt) begin
        WB_ADDR <= gnt_addr;
        WB_DATA <= gnt_data;
      end
    end
  end

endmodule
